// File: rtl/pwm_axil_pkg.sv
// Shared constants and FSM state types for the PWM AXI4-Lite slave front end.
package pwm_axil_pkg;

    localparam int IDX_W = 5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_EXEC,
        R_CAPT,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/pwm_axil_slave.sv
// AXI4-Lite slave that turns bus transactions into single-cycle strobes on the
// pwm_regs register-file ports; independent write and read FSMs.
module pwm_axil_slave
    import pwm_axil_pkg::*;
#(
    parameter int ADDR_WIDTH   = 7,
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,

    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,

    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,

    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,

    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,

    output logic                    write_en,
    output logic [IDX_W-1:0]        write_addr,
    output logic [DATA_WIDTH-1:0]   write_data,

    output logic                    read_en,
    output logic [IDX_W-1:0]        read_addr,
    input  logic [DATA_WIDTH-1:0]   read_data
);

    // Word indices 0..2*NUM_CHANNELS map onto pwm_regs; anything else is a slave error.
    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return int'(idx) <= 2 * NUM_CHANNELS;
    endfunction

    logic [IDX_W-1:0] aw_idx_in;
    logic [IDX_W-1:0] ar_idx_in;
    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             unused_addr_bits;

    assign aw_idx_in = s_axi_awaddr[IDX_W+1:2];
    assign ar_idx_in = s_axi_araddr[IDX_W+1:2];
    assign aw_hs     = s_axi_awvalid && s_axi_awready;
    assign w_hs      = s_axi_wvalid && s_axi_wready;
    assign ar_hs     = s_axi_arvalid && s_axi_arready;
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_t                wr_state, wr_state_n;
    logic                     aw_held, aw_held_n;
    logic                     w_held, w_held_n;
    logic [IDX_W-1:0]         aw_idx_q, aw_idx_n;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_n;
    logic [DATA_WIDTH/8-1:0]  wstrb_q, wstrb_n;
    logic                     awready_n, wready_n, bvalid_n, write_en_n;
    logic [1:0]               bresp_n;
    logic [IDX_W-1:0]         write_addr_n;
    logic [DATA_WIDTH-1:0]    write_data_n;

    always_comb begin
        wr_state_n   = wr_state;
        aw_held_n    = aw_held;
        w_held_n     = w_held;
        aw_idx_n     = aw_idx_q;
        wdata_n      = wdata_q;
        wstrb_n      = wstrb_q;
        awready_n    = s_axi_awready;
        wready_n     = s_axi_wready;
        bvalid_n     = s_axi_bvalid;
        bresp_n      = s_axi_bresp;
        write_en_n   = 1'b0;
        write_addr_n = write_addr;
        write_data_n = write_data;

        case (wr_state)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_n = 1'b1;
                    aw_idx_n  = aw_idx_in;
                end
                if (w_hs) begin
                    w_held_n = 1'b1;
                    wdata_n  = s_axi_wdata;
                    wstrb_n  = s_axi_wstrb;
                end
                awready_n = !aw_held_n;
                wready_n  = !w_held_n;
                // The strobe is registered here so it is high during the W_EXEC cycle.
                if (aw_held_n && w_held_n) begin
                    wr_state_n = W_EXEC;
                    aw_held_n  = 1'b0;
                    w_held_n   = 1'b0;
                    awready_n  = 1'b0;
                    wready_n   = 1'b0;
                    if (idx_in_range(aw_idx_n) && (wstrb_n != '0)) begin
                        write_en_n   = 1'b1;
                        write_addr_n = aw_idx_n;
                        write_data_n = wdata_n;
                    end
                end
            end
            W_EXEC: begin
                bvalid_n   = 1'b1;
                bresp_n    = idx_in_range(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
                wr_state_n = W_RESP;
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_n   = 1'b0;
                    awready_n  = 1'b1;
                    wready_n   = 1'b1;
                    wr_state_n = W_IDLE;
                end
            end
            default: wr_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state      <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            write_en      <= 1'b0;
            write_addr    <= '0;
            write_data    <= '0;
        end else begin
            wr_state      <= wr_state_n;
            aw_held       <= aw_held_n;
            w_held        <= w_held_n;
            aw_idx_q      <= aw_idx_n;
            wdata_q       <= wdata_n;
            wstrb_q       <= wstrb_n;
            s_axi_awready <= awready_n;
            s_axi_wready  <= wready_n;
            s_axi_bvalid  <= bvalid_n;
            s_axi_bresp   <= bresp_n;
            write_en      <= write_en_n;
            write_addr    <= write_addr_n;
            write_data    <= write_data_n;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_t              rd_state, rd_state_n;
    logic [IDX_W-1:0]       ar_idx_q, ar_idx_n;
    logic                   arready_n, read_en_n, rvalid_n;
    logic [IDX_W-1:0]       read_addr_n;
    logic [DATA_WIDTH-1:0]  rdata_n;
    logic [1:0]             rresp_n;

    always_comb begin
        rd_state_n  = rd_state;
        ar_idx_n    = ar_idx_q;
        arready_n   = s_axi_arready;
        read_en_n   = 1'b0;
        read_addr_n = read_addr;
        rvalid_n    = s_axi_rvalid;
        rdata_n     = s_axi_rdata;
        rresp_n     = s_axi_rresp;

        case (rd_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (ar_hs) begin
                    ar_idx_n   = ar_idx_in;
                    arready_n  = 1'b0;
                    rd_state_n = R_EXEC;
                    if (idx_in_range(ar_idx_in)) begin
                        read_en_n   = 1'b1;
                        read_addr_n = ar_idx_in;
                    end
                end
            end
            R_EXEC: rd_state_n = R_CAPT;
            // pwm_regs presents read_data one cycle after read_en.
            R_CAPT: begin
                rvalid_n   = 1'b1;
                rd_state_n = R_RESP;
                if (idx_in_range(ar_idx_q)) begin
                    rdata_n = read_data;
                    rresp_n = RESP_OKAY;
                end else begin
                    rdata_n = '0;
                    rresp_n = RESP_SLVERR;
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    rvalid_n   = 1'b0;
                    arready_n  = 1'b1;
                    rd_state_n = R_IDLE;
                end
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state      <= R_IDLE;
            ar_idx_q      <= '0;
            s_axi_arready <= 1'b0;
            read_en       <= 1'b0;
            read_addr     <= '0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            rd_state      <= rd_state_n;
            ar_idx_q      <= ar_idx_n;
            s_axi_arready <= arready_n;
            read_en       <= read_en_n;
            read_addr     <= read_addr_n;
            s_axi_rvalid  <= rvalid_n;
            s_axi_rdata   <= rdata_n;
            s_axi_rresp   <= rresp_n;
        end
    end

endmodule

// File: doc/pwm_axil_slave.md
# pwm_axil_slave

AXI4-Lite slave front end for the multi-channel PWM generator. It terminates AXI4-Lite write and read transactions from the system interconnect. It converts each transaction into single-cycle `write_en`/`read_en` strobes on the `pwm_regs` register-file port and returns the AXI response. It sits directly upstream of `pwm_regs` and owns all handshake, address-decode and error-response logic, so the register file stays a plain synchronous port.

## Interface
- `ADDR_WIDTH`, 7: AXI byte-address width. The word index is `awaddr/araddr[6:2]`.
- `NUM_CHANNELS`, 4: number of PWM channels. The valid word-index range is 0 to 2*NUM_CHANNELS.
- `DATA_WIDTH`, 32: AXI data width. Fixed at 32.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- AXI write address channel:
  - `s_axi_awaddr` in ADDR_WIDTH
  - `s_axi_awvalid` in 1
  - `s_axi_awready` out 1
- AXI write data channel:
  - `s_axi_wdata` in 32
  - `s_axi_wstrb` in 4
  - `s_axi_wvalid` in 1
  - `s_axi_wready` out 1
- AXI write response channel:
  - `s_axi_bresp` out 2
  - `s_axi_bvalid` out 1
  - `s_axi_bready` in 1
- AXI read address channel:
  - `s_axi_araddr` in ADDR_WIDTH
  - `s_axi_arvalid` in 1
  - `s_axi_arready` out 1
- AXI read data channel:
  - `s_axi_rdata` out 32
  - `s_axi_rresp` out 2
  - `s_axi_rvalid` out 1
  - `s_axi_rready` in 1
- Register-file write port:
  - `write_en` out 1: single-cycle write pulse to `pwm_regs`.
  - `write_addr` out 5: word index.
  - `write_data` out 32.
- Register-file read port:
  - `read_en` out 1: single-cycle read pulse.
  - `read_addr` out 5.
  - `read_data` in 32: registered by `pwm_regs`, valid the cycle after `read_en`.

## Operation
- The write and read paths are independent FSMs and run concurrently. `pwm_regs` has separate ports, so no arbitration is needed.
- Write FSM states: W_IDLE, W_EXEC, W_RESP.
  - W_IDLE: AW and W are captured independently, in either order or in the same cycle. `awready` is high until AW is latched and `wready` is high until W is latched. Each ready drops once its beat is held.
  - When both beats are held, go to W_EXEC.
  - W_EXEC lasts one cycle:
    - If the word index ≤ 2*NUM_CHANNELS and `wstrb` ≠ 0, pulse `write_en` with the latched index and data.
    - An out-of-range index never asserts `write_en`; `bresp` is SLVERR (2'b10).
    - In-range with `wstrb` = 0 asserts no `write_en`; `bresp` is OKAY.
  - W_RESP: `bvalid` stays high until `bready`, then return to W_IDLE.
- Read FSM states: R_IDLE, R_EXEC, R_CAPT, R_RESP.
  - R_IDLE: `arready` is high; an AR handshake latches the index and goes to R_EXEC.
  - R_EXEC: pulse `read_en` with `read_addr` for one cycle.
  - R_CAPT: register `read_data` into `rdata`.
  - R_RESP: `rvalid` stays high until `rready`, then return to R_IDLE.
  - An out-of-range read issues no `read_en`; it returns `rdata` = 0 with SLVERR.
- Outputs are held stable while `valid` is high and `ready` is low.
- `write_addr` and `read_addr` hold their last value between pulses.

## Timing
- Reset value of all outputs: `awready`, `wready`, `arready`, `bvalid`, `rvalid`, `write_en` and `read_en` are 0. All address, data and resp outputs are 0.
  - The ready outputs rise in the first cycle after `rst` deasserts.
- Write latency: the last of AW/W handshakes at edge N → `write_en` high in cycle N+1 → `bvalid` high from cycle N+2.
- Read latency: AR handshake at edge N → `read_en` in cycle N+1 → `read_data` captured at the end of N+2 → `rvalid` high from cycle N+3.
- Throughput:
  - One outstanding write and one outstanding read at a time.
  - A new AW/W is not accepted until B completes; a new AR is not accepted until R completes.
  - `bready` or `rready` held high gives back-to-back transactions every 3 cycles (write) and 4 cycles (read).
- Reset mid-operation: both FSMs return to idle immediately (asynchronously) and all strobes and valids drop. Pending transactions are dropped with no partial `write_en`.
- The same register may be read and written simultaneously; the read returns the old or new value per `pwm_regs` timing, with no extra ordering guarantee.

## Structure
- `pwm_axil_pkg` holds:
  - RESP_OKAY and RESP_SLVERR constants
  - `wr_state_t` and `rd_state_t` enums
  - the index-width constant (5)
- Single module with no sub-modules. The two FSMs are separate `always_ff` blocks in the same file.

## Test plan
- AW and W in the same cycle, addr 0x00, data 123 → `write_en` one cycle with `write_addr` 0 and `write_data` 123; `bresp` OKAY; the `pwm_regs` prescale reads 123.
- W presented 3 cycles before AW, addr 0x04, data 1000 → write held until AW; one `write_en` with index 1; `bvalid` 2 cycles after AW.
- Read at 0x08 after writing 500 there → `read_en` with index 2; `rvalid` 3 cycles after AR; `rdata` 500; OKAY.
- Write to 0x7C and read from 0x7C → no `write_en` or `read_en`; `bresp` and `rresp` are SLVERR; `rdata` 0.
- `bready`/`rready` held low for 5 cycles → `bvalid`/`rvalid` and `rdata` stay stable; no new AW/AR is accepted.
- `rst` asserted during R_CAPT and during W_EXEC → all valids and strobes drop that cycle; the next transaction completes normally.
